// File: rtl/msg_pkg.sv
// Shared constants and LFSR step function for the msg_node message generator.
package msg_pkg;

  // Fibonacci taps 16,14,13,11 as bit positions 0,2,3,5 of a right-shifting register
  localparam logic [15:0] LfsrTaps   = 16'h002D;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LfsrTaps), s[15:1]};
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Power-of-two tx queue; a pop in the same cycle frees the slot for a push when full.
module msg_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_node.sv
// Message node: periodic LFSR message generator feeding a tx FIFO, plus an addressed rx sink.
// Optional even-parity protection on both links is enabled by defining MSG_NODE_PARITY_EN.
module msg_node
  import msg_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned NODE_ID = 0,
  parameter int unsigned PERIOD  = 2,
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] SEED    = DefaultSeed
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ID_W+W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [ID_W+W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [W-1:0]        rx_msg,
  output logic                rx_msg_valid,
  output logic [7:0]          drop_count
`ifdef MSG_NODE_PARITY_EN
  ,
  output logic                tx_par,
  input  logic                rx_par,
  output logic [7:0]          err_count
`endif
);

  localparam int unsigned MW      = ID_W + W;
  localparam int unsigned CntW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_nxt;
  logic            gen;
  logic            fifo_full, fifo_empty, pop, drop;
  logic [7:0]      drop_q;
  logic [W-1:0]    rx_msg_q;
  logic            rx_msg_valid_q;
  logic            rx_hit, par_ok;

  assign gen      = (cnt_q == CntW'(PERIOD - 1));
  assign cnt_d    = gen ? '0 : cnt_q + CntW'(1);
  assign lfsr_nxt = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lfsr_q <= SeedEff;
    end else begin
      cnt_q <= cnt_d;
      if (gen) lfsr_q <= lfsr_nxt;
    end
  end

  msg_fifo #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gen),
    .wdata (lfsr_nxt[MW-1:0]),
    .pop   (pop),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = !fifo_empty;
  assign pop      = tx_valid && tx_ready;
  // A same-cycle pop makes room, so only a full FIFO with no pop loses the message
  assign drop     = gen && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;

  // The sink never stalls, so readiness simply tracks reset
  assign rx_ready = rst_n;

`ifdef MSG_NODE_PARITY_EN
  logic [7:0] err_q;

  assign tx_par = ^tx_data;
  assign par_ok = (rx_par == ^rx_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (rx_valid && rx_ready && !par_ok && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign rx_hit = rx_valid && rx_ready && par_ok && (rx_data[MW-1:W] == ID_W'(NODE_ID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_msg_q       <= '0;
      rx_msg_valid_q <= 1'b0;
    end else begin
      rx_msg_valid_q <= rx_hit;
      if (rx_hit) rx_msg_q <= rx_data[W-1:0];
    end
  end

  assign rx_msg       = rx_msg_q;
  assign rx_msg_valid = rx_msg_valid_q;

endmodule
